ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req_out  output  1  fetch request; memory accepts it in the cycle asserted.
REQ-007 imem_addr_out  output  32  fetch byte address; valid while imem_req_out=1.
REQ-008 imem_ack_in  input  1  response valid; 1..N cycles after request, one ack per request.
REQ-009 imem_rdata_in  input  32  instruction word; valid with imem_ack_in.
REQ-010 stall_in  input  1  decode cannot accept; hold IF/ID outputs.
REQ-011 redirect_in  input  1  taken branch/jump; flush and refetch.
REQ-012 redirect_pc_in  input  32  redirect target; valid with redirect_in.
REQ-013 halt_in  input  1  downstream halt; stop fetching.
REQ-014 instr_out_if  output  32  IF/ID instruction to decode.
REQ-015 pc_out_if  output  32  IF/ID PC of instr_out_if.
REQ-016 valid_out_if  output  1  IF/ID holds a real instruction; consumed when valid_out_if=1 and stall_in=0.
REQ-017 halt_out_if  output  1  fetch-side halt, sticky, to decode's halt input.

Function
REQ-018 SHALL implement states FETCH, WAIT, HOLD, DISCARD, HALT.
REQ-019 FETCH: imem_req_out=1, imem_addr_out=pc; next WAIT. Request is one cycle only.
REQ-020 WAIT, ack, stall_in=0: IF/ID loads {imem_rdata_in, pc, valid=1}; pc<=pc+4; next FETCH.
REQ-021 WAIT, ack, stall_in=1: word captured in a one-entry buffer; next HOLD.
REQ-022 HOLD: when stall_in=0, IF/ID loads the buffer with valid=1; pc<=pc+4; next FETCH.
REQ-023 When stall_in=0 and no instruction is loaded, IF/ID loads {NOP_INSTR, pc, valid=0}. When stall_in=1, IF/ID holds.
REQ-024 Latency: request at cycle N, ack at N+k, valid_out_if=1 at N+k+1 if unstalled. Peak throughput is one instruction per 2 cycles.
REQ-025 pc+4 SHALL wrap modulo 2^32.
REQ-026 Redirect (not HALT) SHALL set pc<=redirect_pc_in and load IF/ID with NOP/valid=0 next cycle, even if stall_in=1.
REQ-027 Redirect also drops any HOLD buffer. Next state: DISCARD if in WAIT with no ack that cycle, else FETCH.
REQ-028 An ack coincident with a redirect SHALL be dropped.
REQ-029 DISCARD: issue no request; drop the next ack, then go to FETCH. A redirect in DISCARD updates pc and stays in DISCARD.
REQ-030 redirect_in with redirect_pc_in[1:0]!=0 SHALL enter HALT and set halt_out_if=1.
REQ-031 halt_in=1 SHALL enter HALT from any state, with priority over redirect and stall.
REQ-032 HALT: imem_req_out=0, valid_out_if=0, halt_out_if=1; exit only by rst.
REQ-033 Acks arriving in FETCH, HOLD or HALT SHALL be ignored.

Reset
REQ-034 With rst=1 at a clock edge: state<=FETCH, pc<=RESET_PC, buffer empty, instr_out_if<=NOP_INSTR, pc_out_if<=0, valid_out_if<=0, halt_out_if<=0.
REQ-035 While rst=1: imem_req_out=0. First request is in the first cycle after rst deasserts, with addr RESET_PC.
REQ-036 Reset mid-WAIT SHALL abandon the outstanding request; its late ack is ignored per REQ-033.

Structure
REQ-037 State encodings and the NOP constant SHALL live in the shared definitions header used by the decode stage.
REQ-038 The IF/ID register (load/hold/flush) SHALL be one sub-module, ifid_reg; the FSM, pc and buffer stay in ifetch_unit.

Verification
REQ-039 Reset, then ack each request 1 cycle later, no stall -> addresses 0,4,8; valid_out_if pulses with matching pc_out_if.
REQ-040 stall_in=1 at the ack for pc=8, held 3 cycles -> previous instr held; on release instr@8 appears once and next request is 0xC.
REQ-041 Redirect to 0x100 while WAIT (ack 2 cycles later) -> that ack dropped, valid_out_if=0, next request addr 0x100.
REQ-042 Redirect to 0x102 -> halt_out_if=1 next cycle, no further imem_req_out until rst.
REQ-043 halt_in and redirect in the same cycle -> HALT, pc unchanged, no request.
REQ-044 RESET_PC=32'hFFFF_FFFC, ack -> next request addr 0x0000_0000.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM state encoding, the RV32 bubble
// instruction and small PC helpers.
package ifetch_unit_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] NOP_INSTR_RV = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_WAIT    = 3'd1,
      ST_HOLD    = 3'd2,
      ST_DISCARD = 3'd3,
      ST_HALT    = 3'd4
   } fetch_state_e;

   function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats load, stall holds, otherwise a bubble
// is loaded whenever no instruction is offered.
module ifid_reg
   import ifetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_RV
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_in,
   input  logic            load_in,
   input  logic            stall_in,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out,
   output logic            valid_out
);

   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush_in) begin
         instr_d = NOP_INSTR;
         pc_d    = pc_in;
         valid_d = 1'b0;
      end else if (!stall_in) begin
         instr_d = load_in ? instr_in : NOP_INSTR;
         pc_d    = pc_in;
         valid_d = load_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr_out = instr_q;
   assign pc_out    = pc_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry stall
// buffer, redirect/discard handling and a sticky halt.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_RV
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ack_in,
   input  logic [31:0] imem_rdata_in,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   input  logic        halt_in,
   output logic [31:0] instr_out_if,
   output logic [31:0] pc_out_if,
   output logic        valid_out_if,
   output logic        halt_out_if
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  buf_q, buf_d;
   logic         buf_vld_q, buf_vld_d;
   logic         halt_q, halt_d;

   logic         redir_take;
   logic         redir_bad;
   logic         go_halt;
   logic         ifid_flush;
   logic         ifid_load;
   logic         buf_capture;
   logic [31:0]  ifid_instr;

   // halt_in outranks redirect; a halted unit ignores redirects entirely
   assign redir_take = redirect_in && !halt_in && (state_q != ST_HALT);
   assign redir_bad  = redir_take && !is_word_aligned(redirect_pc_in);
   assign go_halt    = halt_in || redir_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         buf_vld_q <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         buf_vld_q <= buf_vld_d;
         halt_q    <= halt_d;
      end
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_HALT || go_halt) begin
         state_d = ST_HALT;
      end else if (redir_take) begin
         // a request still in flight must have its ack swallowed
         if ((state_q == ST_WAIT || state_q == ST_DISCARD) && !imem_ack_in)
            state_d = ST_DISCARD;
         else
            state_d = ST_FETCH;
      end else begin
         case (state_q)
            ST_FETCH:   state_d = ST_WAIT;
            ST_WAIT:    if (imem_ack_in) state_d = stall_in ? ST_HOLD : ST_FETCH;
            ST_HOLD:    if (!stall_in) state_d = ST_FETCH;
            ST_DISCARD: if (imem_ack_in) state_d = ST_FETCH;
            default:    state_d = ST_HALT;
         endcase
      end
   end

   always_comb begin
      // no request is launched in a cycle that is being redirected or halted
      imem_req_out  = !rst && (state_q == ST_FETCH) && !redirect_in && !halt_in;
      imem_addr_out = pc_q;
      ifid_flush    = go_halt || redir_take || (state_q == ST_HALT);
      ifid_load     = !ifid_flush && !stall_in &&
                      (((state_q == ST_WAIT) && imem_ack_in) ||
                       ((state_q == ST_HOLD) && buf_vld_q));
      buf_capture   = !ifid_flush && stall_in && (state_q == ST_WAIT) && imem_ack_in;
      ifid_instr    = (state_q == ST_HOLD) ? buf_q : imem_rdata_in;
   end

   always_comb begin
      pc_d      = pc_q;
      buf_d     = buf_q;
      buf_vld_d = buf_vld_q;
      halt_d    = halt_q | go_halt;
      if (redir_take && !redir_bad)
         pc_d = redirect_pc_in;
      else if (ifid_load)
         pc_d = pc_next_seq(pc_q);
      if (buf_capture) begin
         buf_d     = imem_rdata_in;
         buf_vld_d = 1'b1;
      end else if (ifid_flush || ifid_load) begin
         buf_vld_d = 1'b0;
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk       (clk),
      .rst       (rst),
      .flush_in  (ifid_flush),
      .load_in   (ifid_load),
      .stall_in  (stall_in),
      .instr_in  (ifid_instr),
      .pc_in     (pc_q),
      .instr_out (instr_out_if),
      .pc_out    (pc_out_if),
      .valid_out (valid_out_if)
   );

   assign halt_out_if = halt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a default-reset instance for most scenarios
// and a second instance reset near the top of the address space.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ack_in;
   logic [31:0] imem_rdata_in;
   logic        stall_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic        halt_in;

   logic        imem_req_out, imem_req_1;
   logic [31:0] imem_addr_out, imem_addr_1;
   logic [31:0] instr_out_if, instr_1;
   logic [31:0] pc_out_if, pc_1;
   logic        valid_out_if, valid_1;
   logic        halt_out_if, halt_1;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   ifetch_unit u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_out   (imem_req_out),
      .imem_addr_out  (imem_addr_out),
      .imem_ack_in    (imem_ack_in),
      .imem_rdata_in  (imem_rdata_in),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .halt_in        (halt_in),
      .instr_out_if   (instr_out_if),
      .pc_out_if      (pc_out_if),
      .valid_out_if   (valid_out_if),
      .halt_out_if    (halt_out_if)
   );

   ifetch_unit #(
      .RESET_PC (32'hFFFF_FFFC)
   ) u_dut_wrap (
      .clk            (clk),
      .rst            (rst),
      .imem_req_out   (imem_req_1),
      .imem_addr_out  (imem_addr_1),
      .imem_ack_in    (imem_ack_in),
      .imem_rdata_in  (imem_rdata_in),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .halt_in        (halt_in),
      .instr_out_if   (instr_1),
      .pc_out_if      (pc_1),
      .valid_out_if   (valid_1),
      .halt_out_if    (halt_1)
   );

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Leaves both instances in their first FETCH cycle, inputs idle.
   task automatic do_reset;
      rst = 1'b1; imem_ack_in = 1'b0; imem_rdata_in = '0; stall_in = 1'b0;
      redirect_in = 1'b0; redirect_pc_in = '0; halt_in = 1'b0;
      tick; tick;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; imem_ack_in = 1'b0; imem_rdata_in = '0; stall_in = 1'b0;
      redirect_in = 1'b0; redirect_pc_in = '0; halt_in = 1'b0;
      tick; tick;
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem_req_out); end
      checks++; if (valid_out_if !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_out_if); end
      checks++; if (instr_out_if !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_out_if, NOP); end
      checks++; if (pc_out_if !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc_out_if); end
      checks++; if (halt_out_if !== 1'b0) begin errors++; $display("FAIL reset_halt got %0h exp 0", halt_out_if); end
      rst = 1'b0;
      #1;
      checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL first_req got %0h exp 1", imem_req_out); end
      checks++; if (imem_addr_out !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr_out); end
   endtask

   task automatic test_basic;
      logic [31:0] a;
      do_reset;
      for (int i = 0; i < 3; i++) begin
         a = 32'(i * 4);
         checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== a) begin errors++; $display("FAIL basic_req got %0h/%h exp 1/%h", imem_req_out, imem_addr_out, a); end
         tick;
         checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL basic_wait_req got %0h exp 0", imem_req_out); end
         imem_ack_in = 1'b1; imem_rdata_in = 32'hA000_0000 | a;
         tick;
         imem_ack_in = 1'b0;
         #1;
         checks++; if (valid_out_if !== 1'b1 || pc_out_if !== a) begin errors++; $display("FAIL basic_valid got %0h/%h exp 1/%h", valid_out_if, pc_out_if, a); end
         checks++; if (instr_out_if !== (32'hA000_0000 | a)) begin errors++; $display("FAIL basic_instr got %h exp %h", instr_out_if, 32'hA000_0000 | a); end
      end
      tick;
      checks++; if (valid_out_if !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0h exp 0", valid_out_if); end
   endtask

   task automatic test_stall;
      do_reset;
      tick;
      imem_ack_in = 1'b1; imem_rdata_in = 32'hA000_0000;
      tick;
      imem_ack_in = 1'b0;
      // decode stalls while it holds instr@0
      stall_in = 1'b1;
      tick;
      checks++; if (valid_out_if !== 1'b1 || pc_out_if !== 32'h0) begin errors++; $display("FAIL stall_hold_valid got %0h/%h exp 1/0", valid_out_if, pc_out_if); end
      tick;
      checks++; if (instr_out_if !== 32'hA000_0000) begin errors++; $display("FAIL stall_hold_instr got %h exp a0000000", instr_out_if); end
      stall_in = 1'b0; imem_ack_in = 1'b1; imem_rdata_in = 32'hA000_0004;
      tick;
      imem_ack_in = 1'b0;
      #1;
      checks++; if (valid_out_if !== 1'b1 || pc_out_if !== 32'h4) begin errors++; $display("FAIL stall_next got %0h/%h exp 1/4", valid_out_if, pc_out_if); end
      checks++; if (imem_addr_out !== 32'h8) begin errors++; $display("FAIL stall_addr8 got %h exp 8", imem_addr_out); end
      tick;
      imem_ack_in = 1'b1; imem_rdata_in = 32'hA000_0008; stall_in = 1'b1;
      tick;
      imem_ack_in = 1'b0;
      checks++; if (valid_out_if !== 1'b0 || imem_req_out !== 1'b0) begin errors++; $display("FAIL stall_h1 got %0h/%0h exp 0/0", valid_out_if, imem_req_out); end
      // a stray ack while holding must not disturb the buffer
      imem_ack_in = 1'b1; imem_rdata_in = 32'hDEAD_BEEF;
      tick;
      imem_ack_in = 1'b0;
      checks++; if (instr_out_if !== NOP || imem_req_out !== 1'b0) begin errors++; $display("FAIL stall_h2 got %h/%0h exp %h/0", instr_out_if, imem_req_out, NOP); end
      stall_in = 1'b0;
      tick;
      checks++; if (valid_out_if !== 1'b1 || pc_out_if !== 32'h8) begin errors++; $display("FAIL stall_release got %0h/%h exp 1/8", valid_out_if, pc_out_if); end
      checks++; if (instr_out_if !== 32'hA000_0008) begin errors++; $display("FAIL stall_release_instr got %h exp a0000008", instr_out_if); end
      checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'hC) begin errors++; $display("FAIL stall_next_req got %0h/%h exp 1/c", imem_req_out, imem_addr_out); end
      tick;
      checks++; if (valid_out_if !== 1'b0) begin errors++; $display("FAIL stall_once got %0h exp 0", valid_out_if); end
   endtask

   task automatic test_redirect;
      do_reset;
      tick;
      redirect_in = 1'b1; redirect_pc_in = 32'h100;
      tick;
      redirect_in = 1'b0;
      checks++; if (valid_out_if !== 1'b0 || imem_req_out !== 1'b0) begin errors++; $display("FAIL redir_discard got %0h/%0h exp 0/0", valid_out_if, imem_req_out); end
      imem_ack_in = 1'b1; imem_rdata_in = 32'hBADB_AD00;
      tick;
      imem_ack_in = 1'b0;
      #1;
      checks++; if (valid_out_if !== 1'b0 || instr_out_if !== NOP) begin errors++; $display("FAIL redir_drop got %0h/%h exp 0/%h", valid_out_if, instr_out_if, NOP); end
      checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin errors++; $display("FAIL redir_req got %0h/%h exp 1/100", imem_req_out, imem_addr_out); end
      tick;
      imem_ack_in = 1'b1; imem_rdata_in = 32'hA000_0100;
      tick;
      imem_ack_in = 1'b0;
      checks++; if (valid_out_if !== 1'b1 || pc_out_if !== 32'h100) begin errors++; $display("FAIL redir_target got %0h/%h exp 1/100", valid_out_if, pc_out_if); end
      // redirect flushes IF/ID even while decode is stalled
      stall_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h200;
      #1;
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL redir_fetch_req got %0h exp 0", imem_req_out); end
      tick;
      redirect_in = 1'b0; stall_in = 1'b0;
      #1;
      checks++; if (valid_out_if !== 1'b0) begin errors++; $display("FAIL redir_stall_flush got %0h exp 0", valid_out_if); end
      checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200) begin errors++; $display("FAIL redir_req2 got %0h/%h exp 1/200", imem_req_out, imem_addr_out); end
   endtask

   task automatic test_misaligned;
      do_reset;
      tick;
      redirect_in = 1'b1; redirect_pc_in = 32'h102;
      tick;
      redirect_in = 1'b0;
      checks++; if (halt_out_if !== 1'b1 || valid_out_if !== 1'b0) begin errors++; $display("FAIL misalign_halt got %0h/%0h exp 1/0", halt_out_if, valid_out_if); end
      for (int k = 0; k < 4; k++) begin
         imem_ack_in = (k == 1);
         #1;
         checks++; if (imem_req_out !== 1'b0 || halt_out_if !== 1'b1) begin errors++; $display("FAIL misalign_stay got %0h/%0h exp 0/1", imem_req_out, halt_out_if); end
         tick;
      end
      imem_ack_in = 1'b0;
      rst = 1'b1;
      tick;
      checks++; if (halt_out_if !== 1'b0) begin errors++; $display("FAIL misalign_rst got %0h exp 0", halt_out_if); end
      rst = 1'b0;
   endtask

   task automatic test_halt_redirect;
      do_reset;
      tick;
      imem_ack_in = 1'b1; imem_rdata_in = 32'hA000_0000;
      tick;
      imem_ack_in = 1'b0;
      halt_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h40;
      #1;
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL halt_req got %0h exp 0", imem_req_out); end
      tick;
      halt_in = 1'b0; redirect_in = 1'b0;
      #1;
      checks++; if (halt_out_if !== 1'b1 || valid_out_if !== 1'b0) begin errors++; $display("FAIL halt_state got %0h/%0h exp 1/0", halt_out_if, valid_out_if); end
      checks++; if (pc_out_if !== 32'h4) begin errors++; $display("FAIL halt_pc got %h exp 4", pc_out_if); end
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL halt_noreq got %0h exp 0", imem_req_out); end
      end
   endtask

   task automatic test_wrap;
      do_reset;
      checks++; if (imem_req_1 !== 1'b1 || imem_addr_1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %0h/%h exp 1/fffffffc", imem_req_1, imem_addr_1); end
      tick;
      imem_ack_in = 1'b1; imem_rdata_in = 32'hC0FF_EE13;
      tick;
      imem_ack_in = 1'b0;
      #1;
      checks++; if (valid_1 !== 1'b1 || pc_1 !== 32'hFFFF_FFFC || instr_1 !== 32'hC0FF_EE13) begin errors++; $display("FAIL wrap_load got %0h/%h/%h exp 1/fffffffc/c0ffee13", valid_1, pc_1, instr_1); end
      checks++; if (imem_req_1 !== 1'b1 || imem_addr_1 !== 32'h0) begin errors++; $display("FAIL wrap_addr got %0h/%h exp 1/0", imem_req_1, imem_addr_1); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall;
      test_redirect;
      test_misaligned;
      test_halt_redirect;
      test_wrap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
